// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage.
//   fetch_entry_t : one buffered fetch result {pc, instr}
//   state_t       : fetch FSM states (WAIT after reset, RUN otherwise)
//   INSTR_BYTES   : PC increment per instruction word
package fetch_pkg;

  localparam int unsigned INSTR_BYTES = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    WAIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetch_entry_t, with a per-entry registered
// pc+4 stored alongside each entry.
//   clk, rst_n        : clock, synchronous active-low reset
//   push_i / wdata_i  : write an entry (ignored while flush_i is high)
//   pop_i             : remove the head entry
//   flush_i           : empty the FIFO; has priority over push
//   rdata_o           : head entry; rdata_pc_plus4_o : head entry pc + 4
//   count_o, full_o, empty_o : occupancy status
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  fetch_entry_t           wdata_i,
  output fetch_entry_t           rdata_o,
  output logic [31:0]            rdata_pc_plus4_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [31:0]   p4_q  [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
        p4_q[i]  <= 32'(INSTR_BYTES);
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push && !flush_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
        p4_q[wr_ptr_q]  <= wdata_i.pc + 32'(INSTR_BYTES);
      end
    end
  end

  assign rdata_o          = mem_q[rd_ptr_q];
  assign rdata_pc_plus4_o = p4_q[rd_ptr_q];
  assign count_o          = count_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: holds the PC, issues word reads to a 1-cycle
// latency instruction memory, buffers {pc, instr} results and hands them to
// decode.
//   clk, rst_n                  : clock, synchronous active-low reset
//   fetch_en                    : allows new memory requests
//   imem_req, imem_addr         : memory read request / word-aligned address
//   imem_rdata                  : read data, valid the cycle after imem_req
//   redirect_valid, redirect_pc : load a new PC and flush everything stale
//   out_valid/out_ready         : decode handshake; out_instr, out_pc,
//                                 out_pc_plus4 are the head entry
//   dbg_state_o                 : current FSM state
// Handshake: an entry transfers in any cycle where out_valid && out_ready;
// while out_valid && !out_ready the out_* payload holds steady.
module inst_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output state_t      dbg_state_o
);

  localparam int unsigned CNTW = $clog2(DEPTH) + 1;
  localparam int unsigned OCCW = CNTW + 1;

  state_t          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     req_pc_q, req_pc_d;
  logic            inflight_q, inflight_d;
  logic            stale_q, stale_d;
  logic [31:0]     redirect_target;
  logic [CNTW-1:0] fifo_count;
  logic            fifo_full, fifo_empty;
  logic            pop, push, credit_ok;
  logic [OCCW-1:0] occupancy;
  fetch_entry_t    resp_entry, head_entry;

  assign redirect_target = redirect_pc & ~32'h3;
  assign out_valid       = !fifo_empty;
  assign pop             = out_valid && out_ready;

  // Slots already committed: stored entries plus the response on its way,
  // minus the one decode takes this cycle. A request is only issued when
  // its response is guaranteed a slot.
  assign occupancy = OCCW'(fifo_count) + OCCW'(inflight_q) - OCCW'(pop);
  assign credit_ok = (occupancy < OCCW'(DEPTH)) && (!fifo_full || pop);

  // No request goes out in a redirect cycle, so nothing should land the
  // cycle after; the stale flag keeps that response out regardless.
  assign push       = inflight_q && !stale_q;
  assign resp_entry = '{pc: req_pc_q, instr: imem_rdata};

  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    case (state_q)
      WAIT:    state_d  = RUN;
      RUN:     imem_req = fetch_en && !redirect_valid && credit_ok;
      default: state_d  = WAIT;
    endcase
  end

  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = imem_req;
    stale_d    = redirect_valid;
    if (redirect_valid) begin
      pc_d = redirect_target;
    end else if (imem_req) begin
      pc_d     = pc_q + 32'(INSTR_BYTES);
      req_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= WAIT;
      pc_q       <= RESET_PC & ~32'h3;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      stale_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      stale_q    <= stale_d;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk              (clk),
    .rst_n            (rst_n),
    .push_i           (push),
    .pop_i            (pop),
    .flush_i          (redirect_valid),
    .wdata_i          (resp_entry),
    .rdata_o          (head_entry),
    .rdata_pc_plus4_o (out_pc_plus4),
    .count_o          (fifo_count),
    .full_o           (fifo_full),
    .empty_o          (fifo_empty)
  );

  assign imem_addr   = pc_q & ~32'h3;
  assign out_pc      = head_entry.pc;
  assign out_instr   = head_entry.instr;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;
  import fetch_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst_n, fetch_en, imem_req, redirect_valid, out_valid, out_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, out_instr, out_pc, out_pc_plus4;
  state_t      dbg_state;

  int          checks = 0;
  int          errors = 0;
  int          req_count = 0;
  int          req_base;
  logic [31:0] exp_q[$];
  logic [31:0] got_pc[$];
  logic [31:0] exp_addr = RESET_PC;
  logic [31:0] sb_e;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  inst_fetch #(
    .RESET_PC(RESET_PC),
    .DEPTH   (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc_plus4   (out_pc_plus4),
    .dbg_state_o    (dbg_state)
  );

  // Instruction memory: 1-cycle latency, word = byte address >> 2.
  always @(posedge clk) imem_rdata <= imem_req ? (imem_addr >> 2) : 32'hDEAD_BEEF;

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  // Expected address model advances on each request; each request pushes the
  // entry decode must later receive. Redirect/reset discard pending entries.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_addr = RESET_PC;
    end else begin
      if (out_valid && out_ready) begin
        got_pc.push_back(out_pc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL sb_unexpected observed_pc=%h expected=none", out_pc);
        end else begin
          sb_e = exp_q.pop_front();
          check("sb_pc", out_pc, sb_e);
          check("sb_instr", out_instr, sb_e >> 2);
          check("sb_pc_plus4", out_pc_plus4, sb_e + 32'd4);
        end
      end
      if (redirect_valid) begin
        check("no_req_on_redirect", {31'd0, imem_req}, 32'd0);
        exp_q.delete();
        exp_addr = redirect_pc & ~32'h3;
      end else if (imem_req) begin
        check("req_addr", imem_addr, exp_addr);
        exp_q.push_back(exp_addr);
        exp_addr = exp_addr + 32'd4;
        req_count++;
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 32'd0;
    cyc(); cyc();
    smp();
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_pc", out_pc, 32'd0);
    check("rst_instr", out_instr, 32'd0);
    check("rst_pc_plus4", out_pc_plus4, 32'd4);

    // Scenario 1: reset release, streaming with out_ready high.
    cyc(); rst_n = 1'b1;                       // cycle 0 (WAIT)
    smp();
    check("c0_req", {31'd0, imem_req}, 32'd0);
    check("c0_state", 32'(dbg_state), 32'(WAIT));
    cyc(); smp();                              // cycle 1
    check("c1_req", {31'd0, imem_req}, 32'd1);
    check("c1_addr", imem_addr, 32'd0);
    cyc(); smp();                              // cycle 2
    check("c2_valid", {31'd0, out_valid}, 32'd0);
    cyc(); smp();                              // cycle 3
    check("c3_valid", {31'd0, out_valid}, 32'd1);
    check("c3_pc", out_pc, 32'd0);
    check("c3_instr", out_instr, 32'd0);
    check("c3_pc_plus4", out_pc_plus4, 32'd4);
    for (int i = 0; i < 4; i++) begin
      cyc(); smp();
      check("stream_valid", {31'd0, out_valid}, 32'd1);
    end
    check("stream_count", got_pc.size(), 32'd5);
    check("stream_last_pc", got_pc[4], 32'd16);

    // Scenario 2: backpressure right after reset.
    cyc(); rst_n = 1'b0; out_ready = 1'b0;
    cyc(); rst_n = 1'b1;                       // cycle 0
    got_pc.delete();
    req_base = req_count;
    cyc(); cyc(); cyc(); smp();                // cycle 3
    check("stall_valid", {31'd0, out_valid}, 32'd1);
    check("stall_pc", out_pc, 32'd0);
    for (int i = 0; i < 6; i++) begin
      check("stall_noreq", {31'd0, imem_req}, 32'd0);
      check("stall_hold_pc", out_pc, 32'd0);
      check("stall_hold_instr", out_instr, 32'd0);
      if (i < 5) begin cyc(); smp(); end
    end
    check("stall_req_count", req_count - req_base, 32'd2);
    cyc(); out_ready = 1'b1; smp();            // cycle 9
    check("release_req", {31'd0, imem_req}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(); smp();
      check("release_valid", {31'd0, out_valid}, 32'd1);
    end
    check("release_count", got_pc.size(), 32'd4);
    check("release_pc2", got_pc[2], 32'd8);

    // Scenario 3: redirect with a request in flight.
    cyc(); smp();
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; smp();
    got_pc.delete();
    cyc(); redirect_valid = 1'b0; smp();       // R+1
    check("rd_flush_valid", {31'd0, out_valid}, 32'd0);
    check("rd_first_addr", imem_addr, 32'h100);
    cyc(); smp();                              // R+2
    check("rd_r2_valid", {31'd0, out_valid}, 32'd0);
    cyc(); smp();                              // R+3
    check("rd_r3_pc", out_pc, 32'h100);
    cyc(); smp();                              // R+4
    check("rd_r4_pc", out_pc, 32'h104);
    check("rd_count", got_pc.size(), 32'd2);

    // Scenario 4: redirect coinciding with an accepted handshake on 0x10.
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h10; smp();
    got_pc.delete();
    cyc(); redirect_valid = 1'b0;
    cyc();
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h200; smp();
    check("hs_rd_pc", out_pc, 32'h10);
    check("hs_rd_valid", {31'd0, out_valid}, 32'd1);
    cyc(); redirect_valid = 1'b0; smp();
    check("hs_flush_valid", {31'd0, out_valid}, 32'd0);
    cyc(); cyc(); smp();
    check("hs_target_pc", out_pc, 32'h200);
    check("hs_count", got_pc.size(), 32'd2);
    check("hs_first", got_pc[0], 32'h10);
    check("hs_second", got_pc[1], 32'h200);

    // Scenario 5: reset pulse with the FIFO full.
    cyc(); out_ready = 1'b0;
    repeat (4) cyc();
    smp();
    check("full_valid", {31'd0, out_valid}, 32'd1);
    check("full_noreq", {31'd0, imem_req}, 32'd0);
    cyc(); rst_n = 1'b0;
    cyc(); rst_n = 1'b1; out_ready = 1'b1; smp();   // cycle 0
    got_pc.delete();
    check("rst2_valid", {31'd0, out_valid}, 32'd0);
    check("rst2_req", {31'd0, imem_req}, 32'd0);
    cyc(); smp();
    check("rst2_c1_addr", imem_addr, RESET_PC);
    check("rst2_c1_req", {31'd0, imem_req}, 32'd1);
    cyc(); smp();
    check("rst2_c2_valid", {31'd0, out_valid}, 32'd0);
    cyc(); smp();
    check("rst2_c3_pc", out_pc, RESET_PC);
    check("rst2_c3_valid", {31'd0, out_valid}, 32'd1);

    // Scenario 6: fetch_en drop after one request, then address wrap.
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8; smp();
    got_pc.delete();
    req_base = req_count;
    cyc(); redirect_valid = 1'b0; smp();       // R+1
    check("wrap_first_addr", imem_addr, 32'hFFFF_FFF8);
    cyc(); fetch_en = 1'b0; smp();             // R+2
    check("en_off_req", {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      cyc(); smp();
      check("en_off_noreq", {31'd0, imem_req}, 32'd0);
    end
    check("en_off_req_count", req_count - req_base, 32'd1);
    check("en_off_delivered", got_pc.size(), 32'd1);
    check("en_off_pc", got_pc[0], 32'hFFFF_FFF8);
    cyc(); fetch_en = 1'b1; smp();
    check("wrap_addr_fffc", imem_addr, 32'hFFFF_FFFC);
    cyc(); smp();
    check("wrap_addr_0", imem_addr, 32'h0);
    cyc(); smp();
    check("wrap_out_pc", out_pc, 32'hFFFF_FFFC);
    check("wrap_out_plus4", out_pc_plus4, 32'h0);
    cyc(); smp();
    check("wrap_out_pc0", out_pc, 32'h0);

    // Drain and confirm every issued request was delivered.
    cyc(); fetch_en = 1'b0;
    repeat (4) cyc();
    smp();
    check("drain_valid", {31'd0, out_valid}, 32'd0);
    check("drain_sb_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Fetch stage that sits directly upstream of the instruction decoder.
- Holds the PC and issues word reads to a synchronous instruction memory with 1-cycle read latency.
- Buffers returned {pc, instruction} pairs in a small FIFO and presents them to decode over a valid/ready handshake.
- Accepts redirects (branch/jump targets) from later stages, which flush all stale fetches.

Parameters:
- RESET_PC, 32'h0000_0000, byte address fetched first after reset.
- DEPTH, 2, output FIFO entries (power of two, ≥2).

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  synchronous active-low reset
- fetch_en  in  1  permits issuing new memory requests
- imem_req  out  1  read request this cycle
- imem_addr  out  32  byte address of request (bits[1:0] always 0)
- imem_rdata  in  32  instruction; valid the cycle after imem_req
- redirect_valid  in  1  load new PC, flush pipeline
- redirect_pc  in  32  new PC; bits[1:0] ignored, forced 0
- out_valid  out  1  FIFO head valid
- out_ready  in  1  decoder accepts head
- out_instr  out  32  instruction word for decoder
- out_pc  out  32  address of out_instr
- out_pc_plus4  out  32  out_pc + 4 (for branch/jump target formation)

Behaviour:
- Reset (rst_n low at a clock edge):
  - pc = RESET_PC; FIFO emptied; inflight = 0; state = WAIT.
  - Outputs: imem_req = 0, out_valid = 0, out_instr/out_pc = 0, out_pc_plus4 = 4.
  - Reset mid-operation discards any in-flight response.
- FSM:
  - WAIT: one cycle, no request, then always → RUN.
  - RUN: normal fetch.
- Request rule (RUN only):
  - imem_req = fetch_en && !redirect_valid && (count + inflight − pop) < DEPTH, where pop = out_valid && out_ready.
  - On request: imem_addr = pc; pc advances by 4 (32-bit wrap from FFFF_FFFC to 0); inflight = 1 next cycle, else 0.
- Response: in the cycle after a request, {req_pc, imem_rdata} is written to the FIFO unless that response is marked stale.
- Latency: request at cycle N → entry on out_* in cycle N+2.
- Throughput: 1 instruction/cycle sustained with out_ready held high.
- Handshake:
  - out_* hold stable while out_valid && !out_ready.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle are both honoured. A full FIFO with a pop accepts a push.
  - Push into a full FIFO cannot occur, because the credit rule forbids it.
- Redirect (highest priority):
  - Next cycle: pc = {redirect_pc[31:2], 2'b00}, FIFO count = 0.
  - Any response arriving next cycle is marked stale and dropped.
  - No request is issued in the redirect cycle.
  - A handshake completing in the redirect cycle is a valid transfer. Every other entry is discarded.
  - The first post-redirect request is in cycle R+1; its entry appears at R+3.
  - Back-to-back redirects: the last one wins.
- fetch_en low: no new requests; an in-flight response still completes; FIFO drains normally.
- out_pc_plus4 is a registered copy stored per entry, not recomputed combinationally.

Decomposition:
- Package fetch_pkg holds:
  - fetch_entry_t struct {pc[31:0], instr[31:0]}
  - state enum {WAIT, RUN}
  - localparam INSTR_BYTES = 4
- Sub-module fetch_fifo (DEPTH-entry synchronous FIFO of fetch_entry_t):
  - push/pop/flush inputs; count, full, empty outputs
  - flush has priority over push
- Top-level inst_fetch holds the PC, FSM, credit logic and stale tracking.

Test Plan:
- Reset release, memory returns addr>>2, out_ready=1 → first imem_req at cycle 1 addr 0; out_valid at cycle 3 with out_pc=0, out_instr=0, out_pc_plus4=4; then one entry/cycle, pc 4, 8, 12…
- out_ready=0 for 6 cycles after first valid → exactly 2 entries buffered (pc 0, 4); imem_req low once credits exhausted; out_* stable; after release, pc 0, 4, 8 delivered in order, no gaps or duplicates.
- redirect_valid with redirect_pc=0x0000_0103 while one request is in flight → in-flight response dropped, FIFO empty; next out_pc is 0x100, then 0x104; no entry with the old PC appears.
- Redirect in the same cycle as an accepted handshake on pc 0x10 → 0x10 counted as delivered once; next delivered pc equals the redirect target.
- rst_n pulsed low for 1 cycle mid-stream with FIFO full → out_valid 0 the next cycle; fetch restarts at RESET_PC with WAIT timing identical to the first scenario.
- fetch_en=0 right after a request issue → that single response delivered, no further imem_req; with pc preset near 0xFFFF_FFFC, re-enable → addresses wrap FFFF_FFFC → 0000_0000.
